npc_redirect_ctrl: RTL and testbench
====================================

Name: npc_redirect_ctrl

Overview:
- Sequencing controller for the next-PC datapath.
- Every cycle it arbitrates among four sources: EX-stage control-flow redirects (branch/jal/jalr), synchronous traps (ecall), external interrupts, and load-use stalls.
- It drives NPCOp and PCWrite into the next-PC mux, pipeline flush strobes, and the trap CSR state (sepc/scause).
- A small FSM holds the core in a trap-entry window, and a saturating counter tracks redirects for performance debug.

Parameters:
- STVEC_ADDR, 32'h00000090: trap handler entry; informational, must match the NPC mux vector.
- TRAP_HOLD, 2: cycles spent in TRAP_ENTRY after a trap is taken (range 1..15).
- CNT_W, 16: width of the redirect counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_branch_taken  in  1  conditional branch in EX resolved taken
- ex_jal  in  1  jal in EX
- ex_jalr  in  1  jalr in EX
- ex_ecall  in  1  ecall in EX
- pc_ex  in  32  PC of the instruction in EX
- stall_req  in  1  load-use hazard request from hazard unit
- irq  in  1  external interrupt, level-sensitive
- sie  in  1  supervisor interrupt enable
- NPCOp  out  3  next-PC select to NPC mux
- PCWrite  out  1  PC update enable
- flush_ifid  out  1  squash IF/ID
- flush_idex  out  1  squash ID/EX
- irq_ack  out  1  one-cycle pulse when an interrupt is taken
- sepc  out  32  trap return PC, registered
- scause  out  32  trap cause, registered
- in_trap  out  1  FSM in TRAP_ENTRY
- redirect_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Encodings, in a shared package:
  - NPC_PLUS4 = 3'b000, NPC_BRANCH = 3'b001, NPC_JUMP = 3'b010, NPC_JALR = 3'b100, NPC_ECALL = 3'b011.
  - CAUSE_ECALL = 32'd8; CAUSE_SEI = 32'h80000009.
- Outputs NPCOp, PCWrite, flush_* and irq_ack are combinational from the state and inputs. sepc, scause, redirect_cnt and the state are registered.
- Reset (async, rst=1):
  - State RUN; sepc = 0, scause = 0, redirect_cnt = 0, hold counter = 0.
  - While rst is high: PCWrite=0, NPCOp=PLUS4, flush_*=0, irq_ack=0.
- FSM states: RUN, TRAP_ENTRY.
- RUN priority, highest first:
  1. Trap: ex_valid & ex_ecall, or irq & sie.
     - NPCOp=ECALL, PCWrite=1, flush_ifid=flush_idex=1.
     - Next edge: sepc <= pc_ex; hold counter <= TRAP_HOLD-1; state -> TRAP_ENTRY.
     - scause <= CAUSE_ECALL when an ecall is present, even if irq is also pending; the irq stays pending and no irq_ack is issued.
     - Otherwise scause <= CAUSE_SEI and irq_ack=1 for this cycle.
     - An irq with ex_valid=0 still sets sepc <= pc_ex; the bubble's pc_ex is the next PC to execute.
  2. Redirect: ex_valid & (ex_jalr | ex_jal | ex_branch_taken).
     - NPCOp = JALR if ex_jalr, else JUMP if ex_jal, else BRANCH. When several are asserted the order is jalr > jal > branch.
     - PCWrite=1 (overrides stall_req); flush_ifid=flush_idex=1.
     - redirect_cnt += 1, saturating at all-ones.
  3. Stall: stall_req=1 -> NPCOp=PLUS4, PCWrite=0, flushes 0.
  4. Default: NPCOp=PLUS4, PCWrite=1.
- Control bits with ex_valid=0 are ignored.
- TRAP_ENTRY:
  - EX-side redirect and ecall inputs are ignored; irq is masked and irq_ack=0; in_trap=1.
  - NPCOp=PLUS4, PCWrite=~stall_req, flushes 0.
  - The hold counter decrements every cycle, whether or not stall_req is asserted. At 0 the state -> RUN on the next edge.
  - With TRAP_HOLD=1 the FSM spends exactly one cycle in TRAP_ENTRY.
- Latency: trap entry and redirects act on the same cycle as the request (combinational). CSR and counter updates are visible one cycle later.
- Reset asserted mid-TRAP_ENTRY: immediate return to the reset values above, no partial CSR update.

Decomposition:
- Package ctrl_encode_def holds the NPC_* opcodes, CAUSE_* constants, and the FSM state encoding (RUN=1'b0, TRAP_ENTRY=1'b1).
- One natural sub-module: sat_counter (parameter W; inc, clr inputs; saturating output), instantiated for redirect_cnt.
- The arbitration logic stays in the top module.

Test Plan:
- Reset release: rst 1->0 with no requests -> NPCOp=000, PCWrite=1, sepc=0, scause=0, redirect_cnt=0, in_trap=0.
- Branch vs stall: ex_valid=1, ex_branch_taken=1 and stall_req=1 in the same cycle -> NPCOp=001, PCWrite=1, flush_ifid=flush_idex=1, redirect_cnt 0->1. Repeat with ex_valid=0 -> NPCOp=000, PCWrite=0.
- jalr priority: ex_jal=ex_jalr=1, ex_valid=1 -> NPCOp=100.
- Ecall: pc_ex=32'h0000_0040, ex_ecall=1 -> NPCOp=011, flushes=1.
  - Next cycle: sepc=0x40, scause=8, in_trap=1 for exactly 2 cycles (TRAP_HOLD=2), then RUN.
  - A branch presented during TRAP_ENTRY -> ignored (NPCOp=000).
- Interrupt: irq=1, sie=1, pc_ex=32'h100 -> irq_ack pulses once, scause=0x80000009, sepc=0x100. irq held high through TRAP_ENTRY -> no second ack until back in RUN. irq=1, sie=0 -> no trap.
- Counter saturation (CNT_W=4): 20 consecutive redirects -> redirect_cnt stops at 4'hF. Assert rst mid-TRAP_ENTRY -> in_trap=0 and sepc=0 immediately.

Source files
------------

// File: rtl/ctrl_encode_def.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_encode_def (package)
// Description : Shared encodings for the next-PC sequencing logic: NPC mux
//               select codes, trap cause values and the redirect FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_encode_def;

  // Next-PC mux select codes
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_ECALL  = 3'b011;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Trap cause values written to scause
  localparam logic [31:0] CAUSE_ECALL = 32'd8;
  localparam logic [31:0] CAUSE_SEI   = 32'h8000_0009;

  // Redirect FSM state encoding
  localparam int STATE_W = 1;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_RUN        = 1'b0;
  localparam state_t ST_TRAP_ENTRY = 1'b1;

  // Select code for a resolved control-flow redirect; jalr > jal > branch.
  function automatic logic [2:0] redirect_op(input logic jalr, input logic jal);
    if (jalr)     return NPC_JALR;
    else if (jal) return NPC_JUMP;
    else          return NPC_BRANCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones. Synchronous clear
//               has priority over increment.
// Ports       : clk, rst (async, active-high), inc_i, clr_i -> cnt_o[W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/npc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_redirect_ctrl
// Description : Next-PC sequencing controller. Arbitrates traps (ecall, SEI),
//               EX-stage redirects and load-use stalls each cycle, drives the
//               NPC mux select / PC write enable / flushes, keeps sepc/scause,
//               and holds the core in a TRAP_ENTRY window after a trap.
// Ports       : in  : clk, rst, ex_valid, ex_branch_taken, ex_jal, ex_jalr,
//                     ex_ecall, pc_ex[31:0], stall_req, irq, sie
//               out : NPCOp[2:0], PCWrite, flush_ifid, flush_idex, irq_ack,
//                     sepc[31:0], scause[31:0], in_trap,
//                     redirect_cnt[CNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module npc_redirect_ctrl
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] STVEC_ADDR = 32'h0000_0090,
  parameter int          TRAP_HOLD  = 2,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch_taken,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             ex_ecall,
  input  logic [31:0]      pc_ex,
  input  logic             stall_req,
  input  logic             irq,
  input  logic             sie,
  output logic [2:0]       NPCOp,
  output logic             PCWrite,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             irq_ack,
  output logic [31:0]      sepc,
  output logic [31:0]      scause,
  output logic             in_trap,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int HOLD_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(TRAP_HOLD - 1);

  // Elaboration-time sanity checks on the configuration.
  if ((TRAP_HOLD < 1) || (TRAP_HOLD > 15)) begin : g_bad_trap_hold
    $error("TRAP_HOLD must be in 1..15");
  end
  if (STVEC_ADDR[1:0] != 2'b00) begin : g_bad_stvec
    $error("STVEC_ADDR must be word aligned");
  end

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [31:0]        sepc_q, sepc_d;
  logic [31:0]        scause_q, scause_d;

  // Request decode; EX control bits only count for a real instruction.
  logic w_ecall_req;
  logic w_irq_req;
  logic w_redir_req;
  logic w_run;
  logic w_trap_take;
  logic w_redir_take;

  assign w_ecall_req  = ex_valid & ex_ecall;
  assign w_irq_req    = irq & sie;
  assign w_redir_req  = ex_valid & (ex_jalr | ex_jal | ex_branch_taken);
  assign w_run        = (state_q == ST_RUN);
  assign w_trap_take  = w_run & (w_ecall_req | w_irq_req);
  assign w_redir_take = w_run & w_redir_req & ~w_trap_take;

  // --------------------------------------------------------------------------
  // State register (plus trap CSRs and hold counter)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      hold_q   <= '0;
      sepc_q   <= '0;
      scause_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      sepc_q   <= sepc_d;
      scause_q <= scause_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    sepc_d   = sepc_q;
    scause_d = scause_q;
    case (state_q)
      ST_RUN: begin
        if (w_trap_take) begin
          state_d  = ST_TRAP_ENTRY;
          hold_d   = HOLD_INIT;
          // For a bubble, pc_ex is already the next PC to run, so it is
          // still the right return address for an interrupt.
          sepc_d   = pc_ex;
          // A simultaneous ecall wins; the interrupt stays pending.
          scause_d = w_ecall_req ? CAUSE_ECALL : CAUSE_SEI;
        end
      end
      ST_TRAP_ENTRY: begin
        // Counts down regardless of stalls so the window length is fixed.
        if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_RUN;
        hold_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (combinational from state and inputs)
  // --------------------------------------------------------------------------
  always_comb begin
    NPCOp      = NPC_PLUS4;
    PCWrite    = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    irq_ack    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (w_trap_take) begin
            NPCOp      = NPC_ECALL;
            PCWrite    = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            irq_ack    = ~w_ecall_req;
          end else if (w_redir_take) begin
            NPCOp      = redirect_op(ex_jalr, ex_jal);
            PCWrite    = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else begin
            PCWrite    = ~stall_req;
          end
        end
        ST_TRAP_ENTRY: begin
          PCWrite = ~stall_req;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (w_redir_take),
    .clr_i (1'b0),
    .cnt_o (redirect_cnt)
  );

  assign sepc    = sepc_q;
  assign scause  = scause_q;
  assign in_trap = (state_q == ST_TRAP_ENTRY);

endmodule
`default_nettype wire

// File: tb/tb_npc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_redirect_ctrl
// Description : Self-checking bench for npc_redirect_ctrl. Directed scenarios
//               followed by random traffic, all compared against a cycle-level
//               behavioural model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_redirect_ctrl;

  localparam int TRAP_HOLD = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_branch_taken, ex_jal, ex_jalr, ex_ecall;
  logic [31:0]      pc_ex;
  logic             stall_req, irq, sie;
  logic [2:0]       NPCOp;
  logic             PCWrite, flush_ifid, flush_idex, irq_ack, in_trap;
  logic [31:0]      sepc, scause;
  logic [CNT_W-1:0] redirect_cnt;

  always #5 clk = ~clk;

  npc_redirect_ctrl #(
    .STVEC_ADDR (32'h0000_0090),
    .TRAP_HOLD  (TRAP_HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_branch_taken (ex_branch_taken),
    .ex_jal          (ex_jal),
    .ex_jalr         (ex_jalr),
    .ex_ecall        (ex_ecall),
    .pc_ex           (pc_ex),
    .stall_req       (stall_req),
    .irq             (irq),
    .sie             (sie),
    .NPCOp           (NPCOp),
    .PCWrite         (PCWrite),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .irq_ack         (irq_ack),
    .sepc            (sepc),
    .scause          (scause),
    .in_trap         (in_trap),
    .redirect_cnt    (redirect_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: remaining cycles of the trap window, CSRs, count.
  int          m_trap_left;
  logic [31:0] m_sepc;
  logic [31:0] m_scause;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_trap_left = 0;
    m_sepc      = 32'h0;
    m_scause    = 32'h0;
    m_cnt       = 0;
  endtask

  task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic ec, input logic [31:0] pc, input logic st,
                       input logic iq, input logic ie);
    ex_valid = v; ex_branch_taken = br; ex_jal = jal; ex_jalr = jalr;
    ex_ecall = ec; pc_ex = pc; stall_req = st; irq = iq; sie = ie;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic check_outputs();
    logic [2:0] e_npc;
    logic       e_pcw, e_fl, e_ack;
    bit         ecall_v, irq_v, redir_v;
    ecall_v = ex_valid && ex_ecall;
    irq_v   = irq && sie;
    redir_v = ex_valid && (ex_jalr || ex_jal || ex_branch_taken);
    e_npc = 3'b000; e_pcw = !stall_req; e_fl = 1'b0; e_ack = 1'b0;
    if (m_trap_left == 0) begin
      if (ecall_v || irq_v) begin
        e_npc = 3'b011; e_pcw = 1'b1; e_fl = 1'b1; e_ack = !ecall_v;
      end else if (redir_v) begin
        e_pcw = 1'b1; e_fl = 1'b1;
        if (ex_jalr)     e_npc = 3'b100;
        else if (ex_jal) e_npc = 3'b010;
        else             e_npc = 3'b001;
      end
    end
    check("NPCOp",        32'(NPCOp),        32'(e_npc));
    check("PCWrite",      32'(PCWrite),      32'(e_pcw));
    check("flush_ifid",   32'(flush_ifid),   32'(e_fl));
    check("flush_idex",   32'(flush_idex),   32'(e_fl));
    check("irq_ack",      32'(irq_ack),      32'(e_ack));
    check("in_trap",      32'(in_trap),      32'(m_trap_left > 0));
    check("sepc",         sepc,              m_sepc);
    check("scause",       scause,            m_scause);
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
  endtask

  task automatic model_step();
    bit ecall_v, irq_v, redir_v;
    ecall_v = ex_valid && ex_ecall;
    irq_v   = irq && sie;
    redir_v = ex_valid && (ex_jalr || ex_jal || ex_branch_taken);
    if (m_trap_left > 0) begin
      m_trap_left--;
    end else if (ecall_v || irq_v) begin
      m_sepc      = pc_ex;
      m_scause    = ecall_v ? 32'd8 : 32'h8000_0009;
      m_trap_left = TRAP_HOLD;
    end else if (redir_v) begin
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  // Inputs are already driven (just after a rising edge).
  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Outputs held quiet while reset is asserted, even with a request present.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_PCWrite", 32'(PCWrite), 32'd0);
    check("rst_NPCOp",   32'(NPCOp),   32'd0);
    idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset release with no requests.
    run_cycle();

    // Branch beats stall; then the same with a bubble.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0); run_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 1'b0); run_cycle();
    // jalr over jal.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h28, 1'b0, 1'b0, 1'b0); run_cycle();
    // Ecall, then branches during the trap window are ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0); run_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0); run_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 1'b1, 1'b0, 1'b0); run_cycle();
    idle(); run_cycle();
    // Interrupt taken on a bubble, held through the window.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
    repeat (TRAP_HOLD + 2) run_cycle();
    // Ecall together with a pending interrupt: ecall cause, no ack.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1); run_cycle();
    idle(); repeat (TRAP_HOLD) run_cycle();
    // Interrupt masked.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 1'b1, 1'b0); run_cycle();
    // Saturation: 20 consecutive redirects.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 4), 1'b0, 1'b0, 1'b0);
      run_cycle();
    end
    idle(); run_cycle();
    check("cnt_saturated", 32'(redirect_cnt), 32'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0), {$urandom} & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 0));
      run_cycle();
    end

    // Reset asserted in the middle of the trap window.
    idle(); run_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0); run_cycle();
    idle();
    @(negedge clk);
    check("pre_rst_in_trap", 32'(in_trap), 32'd1);
    rst = 1'b1;
    #1;
    check("midtrap_in_trap", 32'(in_trap),      32'd0);
    check("midtrap_sepc",    sepc,              32'd0);
    check("midtrap_scause",  scause,            32'd0);
    check("midtrap_cnt",     32'(redirect_cnt), 32'd0);
    check("midtrap_PCWrite", 32'(PCWrite),      32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0, 1'b0); run_cycle();
    idle(); run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
